sub_seq: RTL

- Parametrised, multi-cycle A − B − Bin subtractor; generalised successor of the team's fixed 8-bit ripple-borrow subtractor.
- Processes the operand one CHUNK-bit slice per clock, LSB slice first, carrying the borrow in a register between slices.
- Start/busy/done handshake; result held stable until the next operation.
- Used where wide subtractions must meet timing without a full-width ripple chain.

---
 rtl/sub_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/sub_seq.sv
// Multi-cycle A - B - Bin subtractor: one CHUNK-bit slice per clock, LSB first,
// borrow carried in a register. Optional macro SUB_SEQ_SAT_EN saturates S to 0 on final borrow.
module sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Bout
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic               brw_q, brw_d, bout_q, bout_d, done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CHUNK-1:0]   a_sl, b_sl, diff;
  logic               brw_nx;

  // Current slice selected by the counter; borrow only ever comes from brw_q.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
    {brw_nx, diff} = {1'b0, a_sl} - {1'b0, b_sl} - {{CHUNK{1'b0}}, brw_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_d     = s_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          brw_d   = Bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (cnt_q == CW'(i)) res_d[i*CHUNK +: CHUNK] = diff;
        end
        brw_d = brw_nx;
        cnt_d = cnt_q + 1'b1;
        // Last slice: publish the whole result at once so partial slices stay hidden.
        if (cnt_q == CW'(NSLICE-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bout_d  = brw_nx;
          s_d     = res_d;
`ifdef SUB_SEQ_SAT_EN
          if (brw_nx) s_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      s_q     <= s_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign S    = s_q;
  assign Bout = bout_q;
endmodule
